// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one byte-wide synchronous SRAM between the CPU (read/write) and the
// video scanout (read-only). One access is in flight at a time. Each access
// runs IDLE -> ISSUE -> READ -> DONE, which absorbs the SRAM's one-cycle
// registered read latency. The winning requester gets a one-cycle ready
// strobe together with the captured read data.
//
// Handshake: a requester raises *_req and holds it, together with its
// address and data, until it sees *_ready. Requests are sampled only in
// IDLE. Address and data are registered at grant, so later changes do not
// affect the access already in flight. A *_req still high in the cycle after
// *_ready is taken as a new request. A request that loses arbitration stays
// pending and is evaluated again in the next IDLE.
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN  When both ports request in the same IDLE cycle,
//                            the port that was not granted last wins.
//                            When undefined, video always wins a tie.
//
// Ports:
//   clock, reset_n       clock; asynchronous active-low reset
//   cpu_req/we/address/wdata -> cpu_rdata/cpu_ready   CPU port
//   vid_req/address          -> vid_rdata/vid_ready   video port
//   address/data_out/write_ena -> SRAM; data_in <- SRAM registered read data
//   dbg_state            current FSM state (0 IDLE, 1 ISSUE, 2 READ, 3 DONE)
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_address,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              write_ena,
    input  logic [DATA_W-1:0] data_in,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_owner_vid;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data_out;
    logic              r_write_ena;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_vid_rdata;
    logic              r_cpu_ready;
    logic              r_vid_ready;
    logic              w_grant_vid;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 1 = CPU wins the next tie; flips on every grant
    logic r_rr_cpu_next;

    always_comb begin
        w_grant_vid = vid_req;
        if (vid_req && cpu_req) begin
            w_grant_vid = ~r_rr_cpu_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_cpu_next <= 1'b1;
        end else if (r_state == S_IDLE && (cpu_req || vid_req)) begin
            r_rr_cpu_next <= w_grant_vid;
        end
    end
`else
    // Fixed priority: video wins any tie
    always_comb begin
        w_grant_vid = vid_req;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_owner_vid <= 1'b0;
            r_address   <= '0;
            r_data_out  <= '0;
            r_write_ena <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_vid_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cpu_ready <= 1'b0;
                    r_vid_ready <= 1'b0;
                    if (cpu_req || vid_req) begin
                        r_owner_vid <= w_grant_vid;
                        if (w_grant_vid) begin
                            r_address   <= vid_address;
                            r_write_ena <= 1'b0;
                        end else begin
                            r_address   <= cpu_address;
                            r_data_out  <= cpu_wdata;
                            // Registered here so the strobe covers exactly the ISSUE cycle
                            r_write_ena <= cpu_we;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_write_ena <= 1'b0;
                    r_state     <= S_READ;
                end
                S_READ: begin
                    // SRAM sampled the address at the end of ISSUE; data_in is valid now
                    if (r_owner_vid) begin
                        r_vid_rdata <= data_in;
                        r_vid_ready <= 1'b1;
                    end else begin
                        r_cpu_rdata <= data_in;
                        r_cpu_ready <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_cpu_ready <= 1'b0;
                    r_vid_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign address   = r_address;
    assign data_out  = r_data_out;
    assign write_ena = r_write_ena;
    assign cpu_rdata = r_cpu_rdata;
    assign vid_rdata = r_vid_rdata;
    assign cpu_ready = r_cpu_ready;
    assign vid_ready = r_vid_ready;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter: directed bench for sram_arbiter with a behavioural
// synchronous SRAM (read-before-write, one-cycle registered read).
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_address = '0;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic              write_ena;
    logic [DATA_W-1:0] data_in = '0;
    logic [1:0]        dbg_state;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .vid_req(vid_req), .vid_address(vid_address),
        .vid_rdata(vid_rdata), .vid_ready(vid_ready),
        .address(address), .data_out(data_out), .write_ena(write_ena),
        .data_in(data_in), .dbg_state(dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clock) begin
        if (write_ena) mem[address] <= data_out;
        data_in <= mem[address];
    end

    // ---------------- bus monitors ----------------
    int we_cnt = 0;
    int we_bad = 0;
    int both_seen = 0;
    logic [ADDR_W-1:0] last_wa = '0;
    logic [DATA_W-1:0] last_wd = '0;
    always @(negedge clock) begin
        if (cpu_ready && vid_ready) both_seen++;
        if (write_ena) begin
            we_cnt++;
            last_wa = address;
            last_wd = data_out;
            if (dbg_state != 2'd1) we_bad++;
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge in IDLE; returns posedges until cpu_ready is seen.
    task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d,
                              output int lat, output logic [DATA_W-1:0] rd);
        cpu_req = 1'b1; cpu_we = we; cpu_address = a; cpu_wdata = d;
        lat = 0;
        do begin
            @(posedge clock); lat++; @(negedge clock);
        end while (!cpu_ready && lat < 20);
        rd = cpu_rdata;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock); @(negedge clock);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int lat, cyc, k, vid_at, cpu_at, cpu_cnt, rst_ready;
    int at3 [0:2];
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] vrd, crd;
    logic [DATA_W-1:0] rd3 [0:2];
    logic [7:0] mask, exp_mask;
    int exp_cpu_cnt;
    int first_at, last_at;

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_state", dbg_state, 0);
        check("rst_address", address, 0);
        check("rst_data_out", data_out, 0);
        check("rst_write_ena", write_ena, 0);
        check("rst_readys", {cpu_ready, vid_ready}, 0);
        check("rst_rdatas", {cpu_rdata, vid_rdata}, 0);
        reset_n = 1'b1;

        // CPU write 0x5A to 0x12345, then read it back
        cpu_access(1'b1, 20'h12345, 8'h5A, lat, rd);
        check("wr_latency", lat, 3);
        check("wr_pulses", we_cnt, 1);
        check("wr_address", last_wa, 32'h12345);
        check("wr_data", last_wd, 32'h5A);
        idle_cycle();
        cpu_access(1'b0, 20'h12345, 8'h00, lat, rd);
        check("rd_latency", lat, 3);
        check("rd_data", rd, 32'h5A);
        check("rd_no_write", we_cnt, 1);

        // preload memory through the CPU port
        idle_cycle(); cpu_access(1'b1, 20'h00010, 8'h77, lat, rd);
        idle_cycle(); cpu_access(1'b1, 20'hB8000, 8'h41, lat, rd);
        idle_cycle(); cpu_access(1'b1, 20'hFFFFE, 8'h11, lat, rd);
        idle_cycle(); cpu_access(1'b1, 20'hFFFFF, 8'h22, lat, rd);
        idle_cycle(); cpu_access(1'b1, 20'h00000, 8'h33, lat, rd);
        idle_cycle(); cpu_access(1'b1, 20'h00020, 8'h99, lat, rd);
        idle_cycle(); cpu_access(1'b1, 20'h00030, 8'hEE, lat, rd);
        check("preload_pulses", we_cnt, 8);

        // simultaneous requests: video first, CPU in the next transaction
        idle_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h00010;
        vid_req = 1'b1; vid_address = 20'hB8000;
        cyc = 0; vid_at = 0; cpu_at = 0; vrd = '0; crd = '0;
        while ((cpu_req || vid_req) && cyc < 40) begin
            @(posedge clock); cyc++; @(negedge clock);
            if (vid_ready && vid_req) begin vid_at = cyc; vrd = vid_rdata; vid_req = 1'b0; end
            if (cpu_ready && cpu_req) begin cpu_at = cyc; crd = cpu_rdata; cpu_req = 1'b0; end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        check("tie_vid_time", vid_at, 3);
        check("tie_cpu_time", cpu_at, 7);
        check("tie_vid_data", vrd, 32'h41);
        check("tie_cpu_data", crd, 32'h77);
        check("tie_vid_hold", vid_rdata, 32'h41);

        // continuous video reads across the address wrap
        idle_cycle();
        vid_req = 1'b1; vid_address = 20'hFFFFE;
        cyc = 0; k = 0;
        while (k < 3 && cyc < 60) begin
            @(posedge clock); cyc++; @(negedge clock);
            if (vid_ready) begin
                rd3[k] = vid_rdata; at3[k] = cyc; k++;
                vid_address = vid_address + 1'b1;
            end
        end
        vid_req = 1'b0;
        check("wrap_count", k, 3);
        check("wrap_rd0", rd3[0], 32'h11);
        check("wrap_rd1", rd3[1], 32'h22);
        check("wrap_rd2", rd3[2], 32'h33);
        check("wrap_t0", at3[0], 3);
        check("wrap_t1", at3[1], 7);
        check("wrap_t2", at3[2], 11);

        // both requests held for 8 transactions
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_mask = 8'hAA; exp_cpu_cnt = 4;
`else
        exp_mask = 8'hFF; exp_cpu_cnt = 0;
`endif
        idle_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h00010;
        vid_req = 1'b1; vid_address = 20'hB8000;
        cyc = 0; k = 0; mask = '0; cpu_cnt = 0; first_at = 0; last_at = 0;
        while (k < 8 && cyc < 80) begin
            @(posedge clock); cyc++; @(negedge clock);
            if (cpu_ready || vid_ready) begin
                mask[k[2:0]] = vid_ready;
                if (cpu_ready) cpu_cnt++;
                if (k == 0) first_at = cyc;
                last_at = cyc;
                k++;
            end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        check("both8_grants", mask, exp_mask);
        check("both8_cpu_count", cpu_cnt, exp_cpu_cnt);
        check("both8_first_time", first_at, 3);
        check("both8_last_time", last_at, 31);
        check("both8_cpu_rdata", cpu_rdata, 32'h77);
        check("both8_vid_rdata", vid_rdata, 32'h41);

        // address change after grant is ignored
        idle_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h00020;
        @(posedge clock); @(negedge clock);
        check("chg_issue_state", dbg_state, 1);
        check("chg_issue_addr", address, 32'h00020);
        cpu_address = 20'h00030;
        lat = 1;
        do begin
            @(posedge clock); lat++; @(negedge clock);
        end while (!cpu_ready && lat < 20);
        check("chg_latency", lat, 3);
        check("chg_data", cpu_rdata, 32'h99);
        check("chg_addr_held", address, 32'h00020);
        cpu_req = 1'b0;

        // reset during ISSUE of a CPU read
        idle_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h12345;
        @(posedge clock); #1;
        check("rst2_in_issue", dbg_state, 1);
        reset_n = 1'b0;
        #1;
        check("rst2_state", dbg_state, 0);
        check("rst2_address", address, 0);
        check("rst2_data_out", data_out, 0);
        check("rst2_rdatas", {cpu_rdata, vid_rdata}, 0);
        check("rst2_ready_we", {cpu_ready, vid_ready, write_ena}, 0);
        rst_ready = 0;
        repeat (3) begin
            @(posedge clock); @(negedge clock);
            if (cpu_ready) rst_ready++;
        end
        check("rst2_no_ready", rst_ready, 0);
        reset_n = 1'b1;
        lat = 0;
        do begin
            @(posedge clock); lat++; @(negedge clock);
        end while (!cpu_ready && lat < 20);
        check("rst2_restart_lat", lat, 3);
        check("rst2_restart_data", cpu_rdata, 32'h5A);
        cpu_req = 1'b0;
        idle_cycle();

        // whole-run bus properties
        check("never_both_ready", both_seen, 0);
        check("we_only_in_issue", we_bad, 0);
        check("total_we_pulses", we_cnt, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single byte-wide, 1 MB synchronous SRAM between the x86 core (read/write) and the video scanout (read-only). It owns the SRAM `address`/`data_out`/`write_ena` bus, sequences one access at a time around the SRAM's one-cycle registered read latency, and returns a single-cycle completion strobe with captured read data to the winning requester.

## Interface
- `ADDR_W`, default 20: SRAM address width (2^20 bytes).
- `DATA_W`, default 8: SRAM data width.

- `clock`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request, level; held until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req`.
- `cpu_address`  in  ADDR_W  CPU byte address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  CPU read data, valid when `cpu_ready`.
- `cpu_ready`  out  1  one-cycle completion strobe.
- `vid_req`  in  1  video read request, level; held until `vid_ready`.
- `vid_address`  in  ADDR_W  video byte address.
- `vid_rdata`  out  DATA_W  video read data, valid when `vid_ready`.
- `vid_ready`  out  1  one-cycle completion strobe.
- `address`  out  ADDR_W  SRAM address.
- `data_out`  out  DATA_W  SRAM write data.
- `write_ena`  out  1  SRAM write strobe.
- `data_in`  in  DATA_W  SRAM registered read data (valid one cycle after address is sampled).

## Operation
- FSM states: IDLE, ISSUE, READ, DONE; one transaction in flight, no pipelining.
- IDLE: if any `*_req`, pick winner, register `address`, `data_out`, write flag and grant owner; -> ISSUE. Else stay.
- ISSUE: `address` held; `write_ena` = 1 only for a CPU write; -> READ.
- READ: `write_ena` = 0; `data_in` now valid; capture into owner's `*_rdata`; set owner's `*_ready`; -> DONE.
- DONE: owner's `*_ready` high this cycle only; -> IDLE.
- Writes follow the identical path; `cpu_rdata` on a write returns the pre-write byte at that address (SRAM read-before-write) and is don't-care to the CPU.
- Arbitration (default): fixed priority, video over CPU.
- `*_rdata` hold last captured value until the next completion for that port.
- Requester keeping `*_req` high through the cycle after `*_ready` is a new request (sampled in IDLE with current address/data).
- Requests sampled only in IDLE; changes to address/data after grant are ignored for the in-flight access.
- Non-winning request is not dropped; it stays pending and is re-evaluated in the next IDLE.

## Timing
- Reset (async assert): state IDLE; `address`=0, `data_out`=0, `write_ena`=0, `cpu_ready`=0, `vid_ready`=0, `cpu_rdata`=0, `vid_rdata`=0; round-robin pointer = CPU-next. In-flight access aborted, no strobe issued; a write aborted in ISSUE may or may not have landed.
- Latency: request sampled at edge E0 -> `write_ena`/address valid cycle 1 -> `*_ready` high in cycle 3 (after E2). Back-to-back service of a continuous request: one access per 4 cycles.
- `write_ena` is never high outside ISSUE and is high for exactly one cycle per write.
- Exactly one of `cpu_ready`/`vid_ready` may be high in any cycle.
- Address wraps naturally at 2^ADDR_W; no range checking.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined: when both requests are present in IDLE, the port not granted last wins (pointer updates on each grant); single requests granted immediately.
- Undefined: fixed priority, video always wins a tie; CPU can starve under continuous video requests.

## Test plan
- CPU write 0x5A to 0x12345, then read 0x12345 -> `write_ena` single pulse with `address`=0x12345, `data_out`=0x5A; read `cpu_ready` 3 cycles after sample with `cpu_rdata`=0x5A.
- `cpu_req` and `vid_req` asserted same cycle (CPU 0x00010, video 0xB8000 holding 0x41) -> video served first (`vid_rdata`=0x41), CPU served in following transaction; no cycle with both readys.
- With `SRAM_ARB_ROUND_ROBIN_EN`, both held high for 8 transactions -> grants alternate CPU, video, CPU, ...; without macro -> video takes all 8, `cpu_ready` never pulses.
- Continuous `vid_req` with address incrementing on each `vid_ready` from 0xFFFFE -> reads 0xFFFFE, 0xFFFFF, 0x00000 at one per 4 cycles.
- `reset_n` pulled low during ISSUE of a CPU read -> all outputs 0 immediately, no `cpu_ready`; after release pending request restarts from IDLE with full 3-cycle latency.
- Change `cpu_address` one cycle after grant -> access uses originally sampled address.
